// File: rtl/accel_op_fsm.sv
// Per-accelerator request sequencer: NUM_SRC strided reads, one op command, one write, then a completion.
// Optional wait-state watchdog enabled by defining ACCEL_TIMEOUT_EN.
module accel_op_fsm #(
    parameter int          ADDRW       = 24,
    parameter logic [1:0]  ACCEL_ID    = 2'b01,
    parameter int          NUM_SRC     = 1,
    parameter int          BLK_STRIDE  = 32,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    input  logic [2*ADDRW+1:0] req_data,
    output logic               ready_req_out,
    input  logic               compq_ready_in,
    output logic [ADDRW:0]     compq_data_out,
    output logic               valid_compq_out,
    output logic               arb_req,
    input  logic               arb_grant,
    input  logic [2:0]         ack_in,
    output logic [ADDRW+7:0]   data_out
);

    localparam logic [1:0] MEM_ID   = 2'b00;
    localparam logic [1:0] LAST_SRC = 2'(NUM_SRC - 1);
    localparam logic [2:0] MEM_ACK  = {1'b1, MEM_ID};
    localparam logic [2:0] ACC_ACK  = {1'b1, ACCEL_ID};

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, OP_REQ, OP_WAIT, WR_REQ, WR_WAIT, DONE
    } state_t;

    state_t               state_reg, state_next;
    logic [2*ADDRW+1:0]   req_reg, req_next;
    logic [1:0]           rd_cnt_reg, rd_cnt_next;
    logic                 err_reg, err_next;
    logic                 timeout_hit;

    logic [1:0]           mode;
    logic [ADDRW-1:0]     src, dst, rd_addr;
    logic [ADDRW+7:0]     rd_word, op_word, wr_word;

    assign mode    = req_reg[2*ADDRW+1 -: 2];
    assign src     = req_reg[2*ADDRW-1 -: ADDRW];
    assign dst     = req_reg[ADDRW-1:0];
    // Truncation to ADDRW bits gives the required address wrap.
    assign rd_addr = src + ADDRW'(32'(rd_cnt_reg) * BLK_STRIDE);
    assign rd_word = {rd_addr, 2'b00, ACCEL_ID, MEM_ID, 2'b01};
    assign op_word = {{ADDRW{1'b0}}, mode, ACCEL_ID, 4'b0011};
    assign wr_word = {dst, 2'b00, MEM_ID, ACCEL_ID, 2'b10};

`ifdef ACCEL_TIMEOUT_EN
    localparam int WCW = $clog2(TIMEOUT_CYC + 1);
    logic [WCW-1:0] wait_cnt_reg;
    logic           in_wait;

    assign in_wait = (state_reg == RD_WAIT) || (state_reg == OP_WAIT) || (state_reg == WR_WAIT);

    // Every *_WAIT is entered from a *_REQ, where the counter sits at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_reg <= '0;
        end else begin
            wait_cnt_reg <= in_wait ? wait_cnt_reg + 1'b1 : '0;
        end
    end

    assign timeout_hit = in_wait && (wait_cnt_reg == WCW'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            req_reg    <= '0;
            rd_cnt_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            req_reg    <= req_next;
            rd_cnt_reg <= rd_cnt_next;
            err_reg    <= err_next;
        end
    end

    // A matching ACK is tested before the watchdog so it wins in the expiry cycle.
    always_comb begin
        state_next  = state_reg;
        req_next    = req_reg;
        rd_cnt_next = rd_cnt_reg;
        err_next    = err_reg;
        case (state_reg)
            IDLE: if (req_valid) begin
                req_next    = req_data;
                rd_cnt_next = '0;
                err_next    = 1'b0;
                state_next  = RD_REQ;
            end
            RD_REQ: if (arb_grant) state_next = RD_WAIT;
            RD_WAIT: begin
                if (ack_in == MEM_ACK) begin
                    if (rd_cnt_reg == LAST_SRC) begin
                        state_next = OP_REQ;
                    end else begin
                        rd_cnt_next = rd_cnt_reg + 1'b1;
                        state_next  = RD_REQ;
                    end
                end else if (timeout_hit) begin
                    err_next   = 1'b1;
                    state_next = DONE;
                end
            end
            OP_REQ: if (arb_grant) state_next = OP_WAIT;
            OP_WAIT: begin
                if (ack_in == ACC_ACK) begin
                    state_next = WR_REQ;
                end else if (timeout_hit) begin
                    err_next   = 1'b1;
                    state_next = DONE;
                end
            end
            WR_REQ: if (arb_grant) state_next = WR_WAIT;
            WR_WAIT: begin
                if (ack_in == MEM_ACK) begin
                    state_next = DONE;
                end else if (timeout_hit) begin
                    err_next   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: if (compq_ready_in) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        arb_req         = 1'b0;
        valid_compq_out = 1'b0;
        data_out        = '0;
        compq_data_out  = '0;
        ready_req_out   = (state_reg == IDLE);
        case (state_reg)
            RD_REQ:  begin arb_req = 1'b1; data_out = rd_word; end
            RD_WAIT: data_out = rd_word;
            OP_REQ:  begin arb_req = 1'b1; data_out = op_word; end
            OP_WAIT: data_out = op_word;
            WR_REQ:  begin arb_req = 1'b1; data_out = wr_word; end
            WR_WAIT: data_out = wr_word;
            DONE: begin
                valid_compq_out = 1'b1;
                compq_data_out  = {err_reg, dst};
            end
            default: ;
        endcase
    end

endmodule
